// File: rtl/mcu_write_if_pkg.sv
// Shared constants for the MCU write interface: word count, word width and
// the byte-lane map selected by {sel1,sel2} (same map as the read path).
package mcu_write_if_pkg;

  localparam int unsigned NUM_WORDS = 2;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;

  // Byte-lane index carried on {sel1,sel2}
  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t BYTE0 = 2'd0;  // bits [7:0]
  localparam byte_idx_t BYTE1 = 2'd1;  // bits [15:8]
  localparam byte_idx_t BYTE2 = 2'd2;  // bits [23:16]
  localparam byte_idx_t BYTE3 = 2'd3;  // bits [31:24], commit byte

endpackage

// File: rtl/mcu_write_if_sync.sv
// Two-flop synchronizer with a configurable width and reset value.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Stage 1 samples the asynchronous input, stage 2 is the usable output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mcu_write_if.sv
// MCU byte-wide write port assembling two 32-bit words. Bytes 0..2 collect
// in a per-word shadow; a byte-3 write commits the word atomically when the
// lower three bytes have all been written, otherwise it flags a sequence
// error and discards the partial word.
module mcu_write_if
  import mcu_write_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_n,
  input  logic              sel0,
  input  logic              sel1,
  input  logic              sel2,
  input  logic [BYTE_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out0,
  output logic [WORD_W-1:0] data_out1,
  output logic              load0,
  output logic              load1,
  output logic              seq_err
);

  localparam int unsigned BUS_W = 1 + 2 + BYTE_W;

  logic             wr_s;
  logic             wr_d3;
  logic [BUS_W-1:0] bus_s;
  logic             wr_rise;
  logic             word_sel;
  byte_idx_t        byte_idx;
  logic [BYTE_W-1:0] byte_data;

  // Shadow holds only bytes 0..2; byte 3 goes straight to the output on
  // commit, so neither the shadow nor the mask needs a fourth lane.
  logic [WORD_W-BYTE_W-1:0] shadow   [NUM_WORDS];
  logic [2:0]               mask     [NUM_WORDS];
  logic [WORD_W-1:0]        word_out [NUM_WORDS];
  logic [NUM_WORDS-1:0]     load;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wr_n),
    .q     (wr_s)
  );

  sync_2ff #(
    .WIDTH     (BUS_W),
    .RESET_VAL ('0)
  ) u_sync_bus (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({sel0, sel1, sel2, data_in}),
    .q     (bus_s)
  );

  // Delayed copy of synchronized wr_n for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_d3 <= 1'b1;
    else        wr_d3 <= wr_s;
  end

  // Decode the synchronized strobe and select/data fields
  always_comb begin
    wr_rise   = wr_s & ~wr_d3;
    word_sel  = bus_s[BUS_W-1];
    byte_idx  = bus_s[BYTE_W +: 2];
    byte_data = bus_s[BYTE_W-1:0];
  end

  // Byte capture, word commit, load pulses and sticky sequence error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        shadow[i]   <= '0;
        mask[i]     <= '0;
        word_out[i] <= '0;
      end
      load    <= '0;
      seq_err <= 1'b0;
    end else begin
      load <= '0;
      if (wr_rise) begin
        case (byte_idx)
          BYTE0: begin
            shadow[word_sel][7:0]   <= byte_data;
            mask[word_sel][0]       <= 1'b1;
          end
          BYTE1: begin
            shadow[word_sel][15:8]  <= byte_data;
            mask[word_sel][1]       <= 1'b1;
          end
          BYTE2: begin
            shadow[word_sel][23:16] <= byte_data;
            mask[word_sel][2]       <= 1'b1;
          end
          BYTE3: begin
            mask[word_sel] <= '0;
            if (&mask[word_sel]) begin
              word_out[word_sel] <= {byte_data, shadow[word_sel]};
              load[word_sel]     <= 1'b1;
            end else begin
              seq_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Map internal word arrays onto the named output ports
  always_comb begin
    data_out0 = word_out[0];
    data_out1 = word_out[1];
    load0     = load[0];
    load1     = load[1];
  end

endmodule

// File: tb/tb_mcu_write_if.sv
// Directed bench for mcu_write_if: a byte/mask/word model updated at the
// expected action edge, compared against the DUT on every falling edge,
// plus literal expectations for each scenario.
module tb_mcu_write_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_n;
  logic        sel0, sel1, sel2;
  logic [7:0]  data_in;
  logic [31:0] data_out0, data_out1;
  logic        load0, load1, seq_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int load0_cnt = 0;
  int load1_cnt = 0;
  int last_load0_cyc = -1;
  int last_load1_cyc = -1;

  // Model state: bytes per word, written flags, committed words, error flag
  logic [7:0]  m_byte  [2][3];
  bit          m_wr    [2][3];
  logic [31:0] m_out   [2];
  bit          m_err;
  bit          m_load  [2];

  mcu_write_if dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_n      (wr_n),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2),
    .data_in   (data_in),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .load0     (load0),
    .load1     (load1),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 3; b++) begin
        m_byte[w][b] = 8'h00;
        m_wr[w][b]   = 1'b0;
      end
      m_out[w]  = 32'h0;
      m_load[w] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_write(input int w, input int b, input logic [7:0] d);
    if (b < 3) begin
      m_byte[w][b] = d;
      m_wr[w][b]   = 1'b1;
    end else begin
      if (m_wr[w][0] && m_wr[w][1] && m_wr[w][2]) begin
        m_out[w]  = {d, m_byte[w][2], m_byte[w][1], m_byte[w][0]};
        m_load[w] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      for (int k = 0; k < 3; k++) m_wr[w][k] = 1'b0;
    end
  endtask

  // One MCU write: setup, low pulse, rise mid-cycle, then hold.
  // Rise lands between edges, so edge N is the next rising edge and the
  // write must appear right after edge N+2.
  task automatic mcu_write(input int w, input int b, input logic [7:0] d);
    logic [1:0] bi;
    bi = 2'(b);
    @(negedge clk);
    sel0 = w[0]; sel1 = bi[1]; sel2 = bi[0]; data_in = d;
    repeat (4) @(negedge clk);
    wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 model_write(w, b, d);
    @(posedge clk);
    #1 m_load[0] = 1'b0; m_load[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      check("data_out0", data_out0, m_out[0]);
      check("data_out1", data_out1, m_out[1]);
      check("load0", {31'b0, load0}, {31'b0, m_load[0]});
      check("load1", {31'b0, load1}, {31'b0, m_load[1]});
      check("seq_err", {31'b0, seq_err}, {31'b0, m_err});
      check("load_exclusive", {31'b0, load0 & load1}, 32'h0);
      if (load0 === 1'b1) begin load0_cnt++; last_load0_cyc = cyc; end
      if (load1 === 1'b1) begin load1_cnt++; last_load1_cyc = cyc; end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int c0, c1;
    model_reset();
    rst_n = 1'b0; wr_n = 1'b1; sel0 = 1'b0; sel1 = 1'b0; sel2 = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out0", data_out0, 32'h0);
    check("rst_seq_err", {31'b0, seq_err}, 32'h0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_spurious_load", 32'(load0_cnt + load1_cnt), 32'd0);

    // Straight word-0 write
    mcu_write(0, 0, 8'h78); mcu_write(0, 1, 8'h56);
    mcu_write(0, 2, 8'h34); mcu_write(0, 3, 8'h12);
    check("t1_out0", data_out0, 32'h12345678);
    check("t1_out1", data_out1, 32'h0);
    check("t1_load0_count", 32'(load0_cnt), 32'd1);

    // Word 1, out-of-order lower bytes
    mcu_write(1, 2, 8'hCC); mcu_write(1, 0, 8'hAA);
    mcu_write(1, 1, 8'hBB); mcu_write(1, 3, 8'hDD);
    check("t2_out1", data_out1, 32'hDDCCBBAA);
    check("t2_out0_kept", data_out0, 32'h12345678);
    check("t2_seq_err", {31'b0, seq_err}, 32'h0);

    // Rewrite byte 1 before completing
    mcu_write(0, 0, 8'h01); mcu_write(0, 1, 8'h11); mcu_write(0, 1, 8'h22);
    mcu_write(0, 2, 8'h33); mcu_write(0, 3, 8'h44);
    check("t3_out0", data_out0, 32'h44332201);
    check("t3_seq_err", {31'b0, seq_err}, 32'h0);

    // Interleaved words
    c0 = load0_cnt; c1 = load1_cnt;
    mcu_write(0, 0, 8'hA0);
    mcu_write(1, 0, 8'h10); mcu_write(1, 1, 8'h20);
    mcu_write(1, 2, 8'h30); mcu_write(1, 3, 8'h40);
    mcu_write(0, 1, 8'hB1); mcu_write(0, 2, 8'hC2); mcu_write(0, 3, 8'hD3);
    check("t4_out0", data_out0, 32'hD3C2B1A0);
    check("t4_out1", data_out1, 32'h40302010);
    check("t4_loads", 32'((load0_cnt - c0) * 16 + (load1_cnt - c1)), 32'h11);
    check("t4_order", {31'b0, last_load1_cyc < last_load0_cyc}, 32'h1);

    // Incomplete commit, then a valid one
    c0 = load0_cnt;
    mcu_write(0, 0, 8'hEE); mcu_write(0, 1, 8'hEF); mcu_write(0, 3, 8'hFF);
    check("t5_out0_kept", data_out0, 32'hD3C2B1A0);
    check("t5_no_load", 32'(load0_cnt - c0), 32'd0);
    check("t5_seq_err", {31'b0, seq_err}, 32'h1);
    mcu_write(0, 0, 8'h21); mcu_write(0, 1, 8'h43);
    mcu_write(0, 2, 8'h65); mcu_write(0, 3, 8'h87);
    check("t5_out0_new", data_out0, 32'h87654321);
    check("t5_seq_err_sticky", {31'b0, seq_err}, 32'h1);

    // Reset mid-word discards the partial word
    apply_reset();
    check("t6_rst_seq_err", {31'b0, seq_err}, 32'h0);
    mcu_write(0, 0, 8'h01); mcu_write(0, 1, 8'h02); mcu_write(0, 2, 8'h03);
    apply_reset();
    mcu_write(0, 3, 8'h04);
    check("t6_out0", data_out0, 32'h0);
    check("t6_seq_err", {31'b0, seq_err}, 32'h1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
